// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, datapath widths and the
// branch-target helper also used by the ID-stage branch comparator.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SKID  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  // Word offset scaled to bytes; overflow wraps silently like the hardware adder.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [31:0] offset);
    return base + {offset[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational selection of the redirect target and the next fetch address
// for the fetch stage.
module next_pc_sel
  import mips_pkg::*;
(
  input  fetch_state_e state,
  input  logic         branch_taken,
  input  logic         jump_valid,
  input  logic [31:0]  branch_offset,
  input  logic [31:0]  branch_base_pc,
  input  logic [25:0]  jump_target,
  input  logic         imem_ready,
  input  logic         stall,
  input  logic [31:0]  imem_addr,
  input  logic [31:0]  redirect_pc,
  output logic         redirect,
  output logic [31:0]  target,
  output logic [31:0]  next_addr
);

  assign redirect = branch_taken | jump_valid;

  // A jump beats a simultaneously resolved branch.
  assign target = jump_valid ? {branch_base_pc[31:28], jump_target, 2'b00}
                             : branch_target(branch_base_pc, branch_offset);

  always_comb begin
    next_addr = imem_addr;
    case (state)
      FETCH: begin
        if (redirect && imem_ready)
          next_addr = target;
        else if (!redirect && imem_ready && !stall)
          next_addr = imem_addr + PC_INC;
      end
      SKID: begin
        if (redirect)
          next_addr = target;
        else if (!stall)
          next_addr = imem_addr + PC_INC;
      end
      DRAIN: begin
        // The outstanding request must complete before the address may move.
        if (imem_ready)
          next_addr = redirect ? target : redirect_pc;
      end
      default: next_addr = imem_addr;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid
// buffer for responses that arrive while decode is stalled.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_offset,
  input  logic [31:0]        branch_base_pc,
  input  logic               jump_valid,
  input  logic [25:0]        jump_target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc_plus4
);

  fetch_state_e       state, next_state;
  logic [INSTR_W-1:0] skid;
  logic [31:0]        redirect_pc;
  logic               redirect;
  logic [31:0]        target;
  logic [31:0]        next_addr;

  next_pc_sel u_next_pc_sel (
    .state          (state),
    .branch_taken   (branch_taken),
    .jump_valid     (jump_valid),
    .branch_offset  (branch_offset),
    .branch_base_pc (branch_base_pc),
    .jump_target    (jump_target),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .imem_addr      (imem_addr),
    .redirect_pc    (redirect_pc),
    .redirect       (redirect),
    .target         (target),
    .next_addr      (next_addr)
  );

  assign imem_req = (state == FETCH) || (state == DRAIN);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = FETCH;
      FETCH: begin
        if (redirect)
          next_state = imem_ready ? FETCH : DRAIN;
        else if (imem_ready && stall)
          next_state = SKID;
      end
      SKID:  if (redirect || !stall) next_state = FETCH;
      DRAIN: if (imem_ready) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      imem_addr      <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      skid           <= '0;
      redirect_pc    <= '0;
    end else begin
      state     <= next_state;
      imem_addr <= next_addr;
      case (state)
        FETCH: begin
          if (redirect) begin
            if_id_valid <= 1'b0;
            if (!imem_ready)
              redirect_pc <= target;
          end else if (imem_ready) begin
            if (!stall) begin
              if_id_instr    <= imem_data;
              if_id_pc_plus4 <= imem_addr + PC_INC;
              if_id_valid    <= 1'b1;
            end else begin
              skid <= imem_data;
            end
          end else if (!stall) begin
            if_id_valid <= 1'b0;
          end
        end
        SKID: begin
          if (redirect) begin
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            if_id_instr    <= skid;
            if_id_pc_plus4 <= imem_addr + PC_INC;
            if_id_valid    <= 1'b1;
          end
        end
        DRAIN: begin
          // Later redirects supersede the one that sent us here.
          if_id_valid <= 1'b0;
          if (redirect)
            redirect_pc <= target;
        end
        default: begin
          if (redirect)
            if_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: hand-computed vectors cover streaming,
// skid, branch/jump redirects, memory-wait drain and mid-operation reset.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] branch_base_pc;
  logic        jump_valid;
  logic [25:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;

  logic        mem_auto;
  logic        man_ready;
  logic [31:0] man_data;

  int checks;
  int errors;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .branch_base_pc (branch_base_pc),
    .jump_valid     (jump_valid),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_data      (imem_data),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory returns the address as data; otherwise driven by hand.
  always_comb begin
    imem_ready = mem_auto ? imem_req  : man_ready;
    imem_data  = mem_auto ? imem_addr : man_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic bt,
                               input logic [31:0] off, input logic [31:0] base,
                               input logic jv, input logic [25:0] jt,
                               input logic rdy, input logic [31:0] data);
    stall          = st;
    branch_taken   = bt;
    branch_offset  = off;
    branch_base_pc = base;
    jump_valid     = jv;
    jump_target    = jt;
    man_ready      = rdy;
    man_data       = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    mem_auto = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_offset = '0; branch_base_pc = '0;
    jump_valid = 1'b0; jump_target = '0; man_ready = 1'b0; man_data = '0;

    #3;
    checkOutput("rst_req",   32'(imem_req), 32'd0);
    checkOutput("rst_addr",  imem_addr, 32'h0);
    checkOutput("rst_valid", 32'(if_id_valid), 32'd0);
    checkOutput("rst_instr", if_id_instr, 32'h0);
    checkOutput("rst_pc4",   if_id_pc_plus4, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_auto = 1'b1;

    $display("[TB] zero-wait streaming");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("str_req0",  32'(imem_req), 32'd1);
    checkOutput("str_addr0", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("str_addr1", imem_addr, 32'h4);
    checkOutput("str_pc4_1", if_id_pc_plus4, 32'h4);
    checkOutput("str_val1",  32'(if_id_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("str_addr2", imem_addr, 32'h8);
    checkOutput("str_pc4_2", if_id_pc_plus4, 32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("str_pc4_3", if_id_pc_plus4, 32'hC);
    checkOutput("str_ins3",  if_id_instr, 32'h8);

    $display("[TB] stall into skid");
    mem_auto = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h2008_0005);
    checkOutput("skid_req",  32'(imem_req), 32'd0);
    checkOutput("skid_ins",  if_id_instr, 32'h8);
    checkOutput("skid_pc4",  if_id_pc_plus4, 32'hC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_0000);
    checkOutput("skid_hold", if_id_instr, 32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_0000);
    checkOutput("skid_rel_ins", if_id_instr, 32'h2008_0005);
    checkOutput("skid_rel_pc4", if_id_pc_plus4, 32'h10);
    checkOutput("skid_rel_adr", imem_addr, 32'h10);
    checkOutput("skid_rel_val", 32'(if_id_valid), 32'd1);

    $display("[TB] taken branch with wrap");
    applyStimulus(0, 1, 32'hFFFF_FFFC, 32'h0000_0010, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("br_addr",  imem_addr, 32'h0);
    checkOutput("br_valid", 32'(if_id_valid), 32'd0);
    checkOutput("br_ins",   if_id_instr, 32'h2008_0005);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    checkOutput("br_tgt_val", 32'(if_id_valid), 32'd1);
    checkOutput("br_tgt_ins", if_id_instr, 32'h1111_1111);
    checkOutput("br_tgt_pc4", if_id_pc_plus4, 32'h4);

    $display("[TB] wait-state bubble");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bub_valid", 32'(if_id_valid), 32'd0);
    checkOutput("bub_addr",  imem_addr, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);
    checkOutput("bub_ins",   if_id_instr, 32'h5555_5555);
    checkOutput("bub_pc4",   if_id_pc_plus4, 32'h8);

    $display("[TB] redirect during memory wait");
    applyStimulus(0, 1, 32'h0000_0004, 32'h0000_0030, 0, 0, 0, 0);
    checkOutput("dr_req",   32'(imem_req), 32'd1);
    checkOutput("dr_addr0", imem_addr, 32'h8);
    checkOutput("dr_valid", 32'(if_id_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dr_addr1", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dr_addr2", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    checkOutput("dr_tgt",   imem_addr, 32'h40);
    checkOutput("dr_val3",  32'(if_id_valid), 32'd0);
    checkOutput("dr_ins3",  if_id_instr, 32'h5555_5555);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    checkOutput("dr_new_ins", if_id_instr, 32'h2222_2222);
    checkOutput("dr_new_pc4", if_id_pc_plus4, 32'h44);

    $display("[TB] jump beats branch");
    applyStimulus(0, 1, 32'h0000_0008, 32'hA000_0004, 1, 26'h000_0100, 1, 32'h7777_7777);
    checkOutput("jmp_addr",  imem_addr, 32'hA000_0400);
    checkOutput("jmp_valid", 32'(if_id_valid), 32'd0);

    $display("[TB] reset while in skid");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
    checkOutput("rs_skid_req", 32'(imem_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs_skid_addr", imem_addr, 32'h0);
    checkOutput("rs_skid_ins",  if_id_instr, 32'h0);
    checkOutput("rs_skid_pc4",  if_id_pc_plus4, 32'h0);
    stall = 1'b0; man_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_skid_fetch", 32'(imem_req), 32'd1);
    checkOutput("rs_skid_adr2",  imem_addr, 32'h0);

    $display("[TB] reset while in drain");
    applyStimulus(0, 0, 0, 0, 1, 26'h000_0010, 0, 0);
    checkOutput("rs_dr_req",  32'(imem_req), 32'd1);
    checkOutput("rs_dr_addr", imem_addr, 32'h0);
    jump_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs_dr_req0", 32'(imem_req), 32'd0);
    checkOutput("rs_dr_val0", 32'(if_id_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_auto = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_dr_adr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_dr_pc4", if_id_pc_plus4, 32'h4);
    checkOutput("rs_dr_val", 32'(if_id_valid), 32'd1);
    checkOutput("rs_dr_nxt", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the MIPS core. It drives the instruction-memory request handshake and presents {instruction, PC+4} to decode. Decode feeds `instruction[15:0]` to the sign extender. The sign-extended offset comes back here, together with jump fields, to redirect the PC. A one-entry skid buffer absorbs a memory response that returns while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: decode cannot accept a new IF/ID entry this cycle.
- `branch_taken` input 1: branch resolved taken in ID.
- `branch_offset` input 32: sign-extended immediate from the sign extender.
- `branch_base_pc` input 32: PC+4 of the branch/jump instruction in ID.
- `jump_valid` input 1: J-type jump in ID.
- `jump_target` input 26: `instr[25:0]` of the jump.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` input 1: response valid this cycle; accepted only when `imem_req`=1.
- `imem_data` input 32: instruction word, valid with `imem_ready`.
- `if_id_valid` output 1: IF/ID entry holds a real instruction.
- `if_id_instr` output 32: fetched instruction.
- `if_id_pc_plus4` output 32: `imem_addr`+4 of that instruction.

## Operation
- Redirect = `branch_taken` | `jump_valid`; jump wins if both.
  - Branch target = `branch_base_pc` + (`branch_offset` << 2), modulo 2^32; wrap-around is silent.
  - Jump target = {`branch_base_pc[31:28]`, `jump_target`, 2'b00}.
- Redirect always clears `if_id_valid` at the next edge and overrides `stall`.
- States: IDLE, FETCH, SKID, DRAIN. `imem_req`=1 in FETCH and DRAIN only.
- IDLE → FETCH unconditionally.
- FETCH:
  - Redirect with `imem_ready`=1: discard `imem_data`; `imem_addr`<=target; stay FETCH.
  - Redirect with `imem_ready`=0: `redirect_pc`<=target; go to DRAIN with `imem_addr` unchanged.
  - `imem_ready`=1, !`stall`: load IF/ID {`imem_data`, `imem_addr`+4}, valid=1; `imem_addr`+=4.
  - `imem_ready`=1, `stall`: skid<=`imem_data`; go to SKID; IF/ID unchanged.
  - `imem_ready`=0: IF/ID holds if `stall`, otherwise `if_id_valid`<=0 (bubble).
- SKID:
  - Redirect: drop skid; `imem_addr`<=target; go to FETCH.
  - !`stall`: IF/ID<=skid, valid=1; `imem_addr`+=4; go to FETCH.
  - Otherwise hold.
- DRAIN (`if_id_valid`=0):
  - Redirect: updates `redirect_pc` (latest wins).
  - `imem_ready`=1: discard data; `imem_addr`<=`redirect_pc`, or the new target if a redirect arrives that cycle; go to FETCH.

## Timing
- Reset values (async, immediate on `rst_n` low): state=IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc_plus4`=0, skid=0, `redirect_pc`=0.
- First edge after `rst_n` rises → FETCH; `imem_req`=1 from that cycle.
- Zero-wait memory (`imem_ready` in the request cycle): IF/ID valid one edge later; throughput 1 instruction/cycle.
- N wait cycles: N bubbles on IF/ID.
- Redirect penalty with zero-wait memory: one flushed slot. The target instruction reaches IF/ID two edges after the redirect cycle.
- Reset asserted mid-DRAIN or mid-SKID: the outstanding response is abandoned; memory must tolerate request withdrawal under reset.
- Only the state encoding and next-address selection are combinational. All outputs except `imem_req` are registered.

## Structure
- Shared `mips_pkg`:
  - State enum.
  - `INSTR_W`=32.
  - Localparam `PC_INC`=4.
  - Function `branch_target(base, offset)` (shared with the ID-stage branch comparator).
- One sub-module, `next_pc_sel`: combinational mux computing the target and the next `imem_addr` from state, redirect, and ready.

## Test plan
- Reset, zero-wait memory returning `addr`: `imem_addr` = 0, 4, 8 on consecutive cycles; `if_id_pc_plus4` = 4, 8, 12, one per cycle.
- `stall` raised in the cycle `imem_ready` returns word 32'h2008_0005 → SKID; IF/ID holds the old value. On `stall` release, `if_id_instr`=32'h2008_0005.
- `branch_taken`, base=32'h0000_0010, offset=32'hFFFF_FFFC → next `imem_addr`=32'h0000_0000; `if_id_valid`=0 for one cycle.
- Redirect during a 3-cycle memory wait → DRAIN; `imem_addr` stays on the old address until ready; then target 32'h0000_0040; discarded data never appears in IF/ID.
- Jump with base 32'hA000_0004, `jump_target`=26'h000_0100 concurrent with `branch_taken` → `imem_addr`=32'hA000_0400.
- `rst_n` pulled low in SKID and in DRAIN → all outputs at reset values immediately; fetch resumes at `RESET_PC`.
